// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared types and default constants for the ROM burst fetch controller.
package rom_fetch_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int LAT_DEF        = 2;
   localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Request and read-data handshake bundle; master is the requester/consumer side.
interface rom_fetch_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18,
   parameter int LEN_W  = 8
) ();
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;

   modport master (
      output req_valid, req_addr, req_len, rd_ready,
      input  req_ready, rd_valid, rd_data, rd_last
   );
   modport slave (
      input  req_valid, req_addr, req_len, rd_ready,
      output req_ready, rd_valid, rd_data, rd_last
   );
endinterface

// File: rtl/rom_fetch_fifo.sv
// Synchronous FIFO buffering captured ROM words; head entry is shown combinationally.
module rom_fetch_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4
) (
   input  logic                       clka,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // simultaneous push and pop leaves the occupancy unchanged
         if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
      end
   end

   always_ff @(posedge clka) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == ($clog2(DEPTH+1))'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/rom_fetch_ctrl.sv
// Burst ROM reader: issues reads under a buffer credit limit, captures them after LAT clocks.
module rom_fetch_ctrl
   import rom_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 18,
   parameter int LAT        = LAT_DEF,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clka,
   input  logic              rst_n,
   rom_fetch_ctrl_if.slave   bus,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   output logic              rom_oe,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy
);
   localparam int IW = $clog2(LAT+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  rem;
   logic [LAT:1]      vld_pipe, last_pipe;
   logic [IW-1:0]     inflight;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   logic              credit_ok, issue, final_issue, accept;
   entry_t            push_ent, head_ent;

   always_comb begin
      inflight = '0;
      for (int i = 1; i <= LAT; i++) inflight = inflight + IW'(vld_pipe[i]);
   end

   // every issued read owns a buffer slot until it is popped, so the FIFO can never overflow
   assign credit_ok   = !fifo_full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
   assign accept      = bus.req_valid && bus.req_ready && (bus.req_len != '0);
   assign final_issue = issue && (rem == LEN_W'(1));

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: if (final_issue) state_nxt = ST_DRAIN;
         ST_DRAIN: if (inflight == '0) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == ST_IDLE);
      busy          = (state != ST_IDLE);
      issue         = (state == ST_ISSUE) && credit_ok;
      rom_en        = issue;
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         rem       <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         if (accept) begin
            cur_addr <= bus.req_addr;
            rem      <= bus.req_len;
         end else if (issue) begin
            cur_addr <= cur_addr + 1'b1;
            rem      <= rem - 1'b1;
         end
         vld_pipe[1]  <= issue;
         last_pipe[1] <= final_issue;
         for (int i = 2; i <= LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end
      end
   end

   assign rom_addr = cur_addr;
   // the ROM drives the shared bus only in the cycle its word is captured
   assign rom_oe   = vld_pipe[LAT];
   assign push_ent = '{last: last_pipe[LAT], data: rom_data};

   rom_fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clka  (clka),
      .rst_n (rst_n),
      .push  (rom_oe),
      .din   (push_ent),
      .pop   (bus.rd_valid && bus.rd_ready),
      .dout  (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.rd_valid = !fifo_empty;
   assign bus.rd_data  = head_ent.data;
   assign bus.rd_last  = !fifo_empty && head_ent.last;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Scoreboard bench for rom_fetch_ctrl with a 2-clock tristate ROM model (mem[i] = i ^ 0x155).
`timescale 1ns/1ps
module tb_rom_fetch_ctrl;
   localparam int ADDR_W = 10, DATA_W = 18, LAT = 2, LEN_W = 8, FIFO_DEPTH = 4;
   localparam int AMASK  = (1 << ADDR_W) - 1;

   logic clka = 1'b0;
   logic rst_n = 1'b0;
   always #5 clka = ~clka;

   rom_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en, rom_oe, busy;
   wire  [DATA_W-1:0] rom_data;

   rom_fetch_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clka(clka), .rst_n(rst_n), .bus(bus), .rom_addr(rom_addr), .rom_en(rom_en),
      .rom_oe(rom_oe), .rom_data(rom_data), .busy(busy)
   );

   // ROM model: address sampled at one edge, data registered at the next
   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [ADDR_W-1:0] rom_a1;
   logic              rom_e1, rom_dv;
   logic [DATA_W-1:0] rom_q;
   initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i ^ 'h155);
   always @(posedge clka) begin
      rom_a1 <= rom_addr;
      rom_e1 <= rom_en;
      rom_q  <= mem[rom_a1];
      rom_dv <= rom_e1;
   end
   assign rom_data = rom_oe ? rom_q : 'z;

   int ecnt = 0;
   always @(posedge clka) ecnt <= ecnt + 1;

   typedef struct { logic [DATA_W-1:0] d; logic l; } exp_t;
   exp_t              exp_q[$];
   int                pop_t[$];
   logic [ADDR_W-1:0] iss_q[$];
   int checks = 0, errors = 0;

   function automatic logic [DATA_W-1:0] exp_word(input int a);
      return DATA_W'((a & AMASK) ^ 'h155);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // rd_ready driver: 0 = hold rdy_fix, 1 = toggle every cycle, 2 = random
   int   rdy_mode = 0;
   logic rdy_fix  = 1'b1;
   initial begin
      bus.rd_ready = 1'b0;
      forever begin
         @(posedge clka); #1;
         case (rdy_mode)
            0:       bus.rd_ready = rdy_fix;
            1:       bus.rd_ready = ~bus.rd_ready;
            default: bus.rd_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // monitor: pops the scoreboard on every transfer, checks stall stability and bus capture
   initial begin
      logic              stall_q = 1'b0;
      logic [DATA_W-1:0] stall_d = '0;
      logic              stall_l = 1'b0;
      exp_t              e;
      forever begin
         @(negedge clka);
         if (!rst_n) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               chk("stall_valid", 32'(bus.rd_valid), 32'd1);
               chk("stall_data", 32'(bus.rd_data), 32'(stall_d));
               chk("stall_last", 32'(bus.rd_last), 32'(stall_l));
            end
            if (rom_oe) chk("oe_without_capture", 32'(rom_dv), 32'd1);
            if (rom_en) iss_q.push_back(rom_addr);
            if (bus.rd_valid && bus.rd_ready) begin
               pop_t.push_back(ecnt);
               if (exp_q.size() == 0) chk("spurious_rd_valid", 32'(bus.rd_valid), 32'd0);
               else begin
                  e = exp_q.pop_front();
                  chk("rd_data", 32'(bus.rd_data), 32'(e.d));
                  chk("rd_last", 32'(bus.rd_last), 32'(e.l));
               end
            end
            stall_q = bus.rd_valid && !bus.rd_ready;
            stall_d = bus.rd_data;
            stall_l = bus.rd_last;
         end
      end
   end

   // acc_e is the cycle count at the negedge before the accepting edge
   task automatic send(input int addr, input int len, output int acc_e);
      bit done = 1'b0;
      acc_e = -1;
      @(posedge clka); #1;
      bus.req_valid = 1'b1;
      bus.req_addr  = ADDR_W'(addr);
      bus.req_len   = LEN_W'(len);
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clka);
         if (bus.req_ready) begin
            done  = 1'b1;
            acc_e = ecnt;
            for (int i = 0; i < len; i++)
               exp_q.push_back('{d: exp_word(addr + i), l: (i == len - 1)});
         end
      end
      if (!done) chk("req_accept_timeout", 32'(bus.req_ready), 32'd1);
      @(posedge clka); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      bit done = 1'b0;
      for (int n = 0; n < max_cyc && !done; n++) begin
         @(negedge clka);
         if (exp_q.size() == 0 && !busy && !bus.rd_valid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int acc, a, en_seen, rv_seen, busy_seen;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      repeat (3) @(negedge clka);
      chk("rst_rom_en", 32'(rom_en), 32'd0);
      chk("rst_rom_oe", 32'(rom_oe), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_last", 32'(bus.rd_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clka); #1 rst_n = 1'b1;

      // basic burst: accepted at edge k+1, first word visible after edge k+1+LAT+1
      pop_t.delete();
      send('h010, 4, acc);
      wait_drain(100);
      chk("s1_words", 32'(pop_t.size()), 32'd4);
      if (pop_t.size() == 4) begin
         chk("s1_latency", 32'(pop_t[0] - acc), 32'(LAT + 2));
         chk("s1_back_to_back", 32'(pop_t[3] - pop_t[0]), 32'd3);
      end

      // address wrap-around
      iss_q.delete();
      send('h3FE, 4, acc);
      wait_drain(100);
      chk("s2_issues", 32'(iss_q.size()), 32'd4);
      for (int i = 0; i < iss_q.size() && i < 4; i++)
         chk("s2_rom_addr", 32'(iss_q[i]), 32'(('h3FE + i) & AMASK));

      // back-pressure: only FIFO_DEPTH reads may be issued while the consumer stalls
      rdy_fix = 1'b0;
      @(posedge clka);
      iss_q.delete();
      pop_t.delete();
      send(int'($urandom_range(0, AMASK)), 16, acc);
      en_seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clka);
         if (n >= 10 && rom_en) en_seen++;
      end
      chk("s3_issued_stalled", 32'(iss_q.size()), 32'(FIFO_DEPTH));
      chk("s3_rom_en_held_low", 32'(en_seen), 32'd0);
      chk("s3_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("s3_no_pop", 32'(pop_t.size()), 32'd0);
      rdy_fix = 1'b1;
      wait_drain(200);
      chk("s3_words", 32'(pop_t.size()), 32'd16);
      chk("s3_issued_total", 32'(iss_q.size()), 32'd16);

      // zero-length request
      pop_t.delete();
      send(int'($urandom_range(0, AMASK)), 0, acc);
      chk("s4_accepted", 32'(acc >= 0), 32'd1);
      busy_seen = 0;
      rv_seen   = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clka);
         busy_seen += int'(busy);
         rv_seen   += int'(bus.rd_valid);
      end
      chk("s4_busy", 32'(busy_seen), 32'd0);
      chk("s4_rd_valid", 32'(rv_seen), 32'd0);

      // reset in the middle of a burst
      send(int'($urandom_range(0, AMASK)), 8, acc);
      repeat (2) @(posedge clka);
      #3 rst_n = 1'b0;
      #1;
      chk("s5_rom_en", 32'(rom_en), 32'd0);
      chk("s5_rom_oe", 32'(rom_oe), 32'd0);
      chk("s5_rom_addr", 32'(rom_addr), 32'd0);
      chk("s5_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("s5_rd_last", 32'(bus.rd_last), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clka);
      @(posedge clka); #1 rst_n = 1'b1;
      @(negedge clka);
      chk("s5_req_ready_after_release", 32'(bus.req_ready), 32'd1);
      rv_seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clka);
         rv_seen += int'(bus.rd_valid);
      end
      chk("s5_no_stale_word", 32'(rv_seen), 32'd0);

      // rd_ready toggling every cycle
      rdy_mode = 1;
      pop_t.delete();
      send(int'($urandom_range(0, AMASK)), 8, acc);
      wait_drain(200);
      chk("s6_words", 32'(pop_t.size()), 32'd8);

      // random bursts, random back-pressure
      rdy_mode = 2;
      for (int b = 0; b < 12; b++) begin
         a = int'($urandom_range(0, AMASK));
         send(a, int'($urandom_range(0, 12)), acc);
      end
      wait_drain(2000);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
